// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter for NUM_MASTERS masters.
// Fixed-priority or round-robin arbitration (ARB_MODE), burst-aware grant
// hand-over, locked-transfer holding. Define AHB_ARB_SPLIT_EN to add the
// HSPLIT port and SPLIT masking; without it SPLIT behaves like RETRY.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int ARB_MODE       = 0,
  parameter int MW             = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
`ifdef AHB_ARB_SPLIT_EN
  input  logic [NUM_MASTERS-1:0] HSPLIT,
`endif
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] BU_WRAP4  = 3'b010;
  localparam logic [2:0] BU_INCR4  = 3'b011;
  localparam logic [2:0] BU_WRAP8  = 3'b100;
  localparam logic [2:0] BU_INCR8  = 3'b101;
  localparam logic [2:0] BU_WRAP16 = 3'b110;
  localparam logic [2:0] BU_INCR16 = 3'b111;

  localparam logic [NUM_MASTERS-1:0] ONE     = NUM_MASTERS'(1);
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = ONE << DEFAULT_MASTER;

  typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic                   hmlock_q, hmlock_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   rel_q, rel_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;

  logic [MW-1:0]          owner_idx;
  logic                   lock_g;
  logic [NUM_MASTERS-1:0] req_eff;
  logic [MW-1:0]          arb_idx;
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [3:0]             burst_len;
  logic                   do_arb;

`ifdef AHB_ARB_SPLIT_EN
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  logic [NUM_MASTERS-1:0] mask_q, mask_d, mask_set;

  // Split mask: set for the address-phase owner on the second SPLIT cycle,
  // cleared by HSPLIT on any edge so a one-cycle strobe is never lost.
  // A fresh set already excludes the master from this edge's arbitration.
  always_comb begin
    mask_set = '0;
    if (HREADY && (HRESP == RESP_SPLIT)) mask_set = ONE << hmaster_q;
    mask_d  = (mask_q | mask_set) & ~HSPLIT;
    req_eff = HBUSREQ & ~(mask_q | mask_set);
  end

  // Split mask register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) mask_q <= '0;
    else          mask_q <= mask_d;
  end
`else
  // Without split support every request is eligible
  always_comb begin
    req_eff = HBUSREQ;
  end
`endif

  // Index of the currently granted master and its lock request
  always_comb begin
    owner_idx = DEF_IDX;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) owner_idx = MW'(i);
    end
    lock_g = |(HLOCK & grant_q);
  end

  // Arbitration: lowest index (fixed) or first requester after the RR pointer;
  // the loops run from lowest to highest priority so the last hit wins.
  always_comb begin
    int                     c;
    logic [NUM_MASTERS-1:0] rot;
    c       = 0;
    rot     = '0;
    arb_idx = DEF_IDX;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req_eff[i]) arb_idx = MW'(i);
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        c = int'(rr_ptr_q) + k;
        if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
        rot = req_eff >> c;
        if (rot[0]) arb_idx = MW'(c);
      end
    end
    arb_gnt = ONE << arb_idx;
  end

  // Remaining-beat count to load for fixed-length bursts (0 = not held)
  always_comb begin
    case (HBURST)
      BU_WRAP4,  BU_INCR4:  burst_len = 4'd3;
      BU_WRAP8,  BU_INCR8:  burst_len = 4'd7;
      BU_WRAP16, BU_INCR16: burst_len = 4'd15;
      default:              burst_len = 4'd0;
    endcase
  end

  // Next-state logic; nothing moves unless the bus accepts a transfer
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hmaster_d = hmaster_q;
    hmlock_d  = hmlock_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    rr_ptr_d  = rr_ptr_q;
    do_arb    = 1'b0;
    if (HREADY) begin
      hmaster_d = owner_idx;
      hmlock_d  = lock_g;
      case (state_q)
        ARB: begin
          if (lock_g) begin
            state_d = LOCKED;
            rel_d   = 1'b0;
          end else if ((HTRANS == TR_NONSEQ) && (burst_len != 4'd0)) begin
            state_d = BURST;
            cnt_d   = burst_len;
          end else begin
            do_arb = 1'b1;
          end
        end
        BURST: begin
          if ((HRESP != RESP_OKAY) || (HTRANS == TR_IDLE) || (HTRANS == TR_NONSEQ)) begin
            state_d = ARB;
            do_arb  = 1'b1;
          end else if (HTRANS == TR_SEQ) begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            // Hand over once the penultimate beat is accepted
            if (cnt_q <= 4'd2) begin
              state_d = ARB;
              do_arb  = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (rel_q) begin
            state_d = ARB;
            rel_d   = 1'b0;
            do_arb  = 1'b1;
          end else if (!lock_g) begin
            rel_d = 1'b1;
          end
        end
        default: begin
          state_d = ARB;
        end
      endcase
      if (do_arb) begin
        grant_d = arb_gnt;
        if (arb_gnt != grant_q) rr_ptr_d = arb_idx;
      end
    end
  end

  // State and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ARB;
      grant_q   <= DEF_GNT;
      hmaster_q <= DEF_IDX;
      hmlock_q  <= 1'b0;
      cnt_q     <= 4'd0;
      rel_q     <= 1'b0;
      rr_ptr_q  <= DEF_IDX;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      hmaster_q <= hmaster_d;
      hmlock_q  <= hmlock_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: a fixed-priority 2-master instance and a
// round-robin 3-master instance share clock, reset and bus signals.
// Expected outputs are queued per accepted edge and checked by a monitor.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] RETRY  = 2'b10;
  localparam logic [1:0] SPLIT  = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [1:0] htrans = IDLE;
  logic [2:0] hburst = SINGLE;
  logic       hready = 1'b1;
  logic [1:0] hresp = OKAY;

  logic [1:0] f_req = '0, f_lock = '0;
  logic [2:0] r_req = '0, r_lock = '0;
  logic [1:0] f_gnt;
  logic [3:0] f_mst;
  logic       f_ml;
  logic [2:0] r_gnt;
  logic [3:0] r_mst;
  logic       r_ml;
`ifdef AHB_ARB_SPLIT_EN
  logic [1:0] f_split = '0;
  logic [2:0] r_split = '0;
`endif

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(.NUM_MASTERS(2), .DEFAULT_MASTER(0), .ARB_MODE(0), .MW(4)) u_fix (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(f_req), .HLOCK(f_lock),
    .HTRANS(htrans), .HBURST(hburst), .HREADY(hready), .HRESP(hresp),
`ifdef AHB_ARB_SPLIT_EN
    .HSPLIT(f_split),
`endif
    .HGRANT(f_gnt), .HMASTER(f_mst), .HMASTLOCK(f_ml)
  );

  ahb_bus_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0), .ARB_MODE(1), .MW(4)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(r_req), .HLOCK(r_lock),
    .HTRANS(htrans), .HBURST(hburst), .HREADY(hready), .HRESP(hresp),
`ifdef AHB_ARB_SPLIT_EN
    .HSPLIT(r_split),
`endif
    .HGRANT(r_gnt), .HMASTER(r_mst), .HMASTLOCK(r_ml)
  );

  typedef struct {
    int         id;
    string      name;
    logic [3:0] g;
    logic [3:0] m;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Monitor: drain the scoreboard shortly after each falling clock edge and
  // right after reset assertion (so async reset is seen before any rising edge)
  always begin
    exp_t       e;
    logic [3:0] ag, am;
    logic       al;
    @(negedge HCLK or negedge HRESETn);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.id == 0) begin
        ag = {2'b00, f_gnt}; am = f_mst; al = f_ml;
      end else begin
        ag = {1'b0, r_gnt};  am = r_mst; al = r_ml;
      end
      n_chk++;
      if (ag === e.g && am === e.m && al === e.l) n_pass++;
      else $display("FAIL %s: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                    e.name, ag, am, al, e.g, e.m, e.l);
    end
  end

  task automatic expf(input string n, input logic [1:0] g, input logic [3:0] m, input logic l);
    exp_t e;
    e.id = 0; e.name = n; e.g = {2'b00, g}; e.m = m; e.l = l;
    sb.push_back(e);
  endtask

  task automatic expr(input string n, input logic [2:0] g, input logic [3:0] m, input logic l);
    exp_t e;
    e.id = 1; e.name = n; e.g = {1'b0, g}; e.m = m; e.l = l;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    htrans = IDLE; hburst = SINGLE; hready = 1'b1; hresp = OKAY;
    f_req = '0; f_lock = '0; r_req = '0; r_lock = '0;
`ifdef AHB_ARB_SPLIT_EN
    f_split = '0; r_split = '0;
`endif
  endtask

  // Assert reset between rising edges; outputs must change before the next one
  task automatic do_reset(input string n);
    @(negedge HCLK);
    #2;
    expf(n, 2'b01, 4'd0, 1'b0);
    expr(n, 3'b001, 4'd0, 1'b0);
    HRESETn = 1'b0;
    idle_inputs();
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    do_reset("rst_init");

    // Move both instances away from the reset state, then reset mid-cycle
    f_req = 2'b10; r_req = 3'b010;
    tick(); expf("pre_rst_f1", 2'b10, 4'd0, 1'b0); expr("pre_rst_r1", 3'b010, 4'd0, 1'b0);
    tick(); expf("pre_rst_f2", 2'b10, 4'd1, 1'b0); expr("pre_rst_r2", 3'b010, 4'd1, 1'b0);
    do_reset("async_rst");
    n_chk++;
    if (f_gnt === 2'b01 && f_mst === 4'd0 && f_ml === 1'b0 &&
        r_gnt === 3'b001 && r_mst === 4'd0 && r_ml === 1'b0) n_pass++;
    else $display("FAIL post_rst: f grant=%b master=%0d lock=%b, r grant=%b master=%0d lock=%b",
                  f_gnt, f_mst, f_ml, r_gnt, r_mst, r_ml);

    // Fixed priority: master 0 keeps the bus against master 1
    f_req = 2'b11; htrans = NONSEQ; hburst = SINGLE;
    for (int i = 0; i < 4; i++) begin
      tick(); expf("fix_hold", 2'b01, 4'd0, 1'b0);
    end

    // Round robin over three masters; HMASTER trails by one transfer
    do_reset("rst_rr");
    r_req = 3'b111; htrans = NONSEQ; hburst = SINGLE;
    tick(); expr("rr_m1", 3'b010, 4'd0, 1'b0);
    tick(); expr("rr_m2", 3'b100, 4'd1, 1'b0);
    tick(); expr("rr_m0", 3'b001, 4'd2, 1'b0);
    tick(); expr("rr_m1b", 3'b010, 4'd0, 1'b0);

    // INCR4 by master 0 with a wait state and a BUSY; hand-over on beat 3
    do_reset("rst_burst");
    f_req = 2'b10; htrans = NONSEQ; hburst = INCR4;
    tick(); expf("b_nonseq", 2'b01, 4'd0, 1'b0);
    htrans = SEQ; hready = 1'b0;
    tick(); expf("b_wait", 2'b01, 4'd0, 1'b0);
    hready = 1'b1;
    tick(); expf("b_beat2", 2'b01, 4'd0, 1'b0);
    htrans = BUSY;
    tick(); expf("b_busy", 2'b01, 4'd0, 1'b0);
    htrans = SEQ;
    tick(); expf("b_beat3", 2'b10, 4'd0, 1'b0);
    tick(); expf("b_beat4", 2'b10, 4'd1, 1'b0);

    // Locked master 1 over two INCR4 bursts while master 0 requests
    do_reset("rst_lock");
    f_req = 2'b10; f_lock = 2'b10; htrans = IDLE; hburst = SINGLE;
    tick(); expf("lk_arb", 2'b10, 4'd0, 1'b0);
    tick(); expf("lk_enter", 2'b10, 4'd1, 1'b1);
    f_req = 2'b11; hburst = INCR4;
    for (int b = 0; b < 8; b++) begin
      htrans = ((b % 4) == 0) ? NONSEQ : SEQ;
      tick(); expf("lk_hold", 2'b10, 4'd1, 1'b1);
    end
    f_lock = 2'b00; htrans = IDLE; hburst = SINGLE;
    tick(); expf("lk_last", 2'b10, 4'd1, 1'b0);
    tick(); expf("lk_release", 2'b01, 4'd1, 1'b0);
    tick(); expf("lk_newown", 2'b01, 4'd0, 1'b0);

    // RETRY during a burst ends it on the second response cycle
    do_reset("rst_retry");
    f_req = 2'b10; htrans = NONSEQ; hburst = INCR4;
    tick(); expf("rt_nonseq", 2'b01, 4'd0, 1'b0);
    htrans = SEQ;
    tick(); expf("rt_seq", 2'b01, 4'd0, 1'b0);
    htrans = BUSY; hresp = RETRY; hready = 1'b0;
    tick(); expf("rt_wait", 2'b01, 4'd0, 1'b0);
    hready = 1'b1;
    tick(); expf("rt_exit", 2'b10, 4'd0, 1'b0);
    hresp = OKAY; htrans = IDLE;
    tick(); expf("rt_own", 2'b10, 4'd1, 1'b0);

`ifdef AHB_ARB_SPLIT_EN
    // SPLIT masks master 0 until its HSPLIT strobe
    do_reset("rst_split");
    f_req = 2'b11; htrans = NONSEQ; hburst = SINGLE;
    tick(); expf("sp_own", 2'b01, 4'd0, 1'b0);
    htrans = IDLE; hready = 1'b0; hresp = SPLIT;
    tick(); expf("sp_wait", 2'b01, 4'd0, 1'b0);
    hready = 1'b1;
    tick(); expf("sp_mask", 2'b10, 4'd0, 1'b0);
    hresp = OKAY;
    tick(); expf("sp_masked", 2'b10, 4'd1, 1'b0);
    f_split = 2'b01;
    tick(); expf("sp_clr", 2'b10, 4'd1, 1'b0);
    f_split = 2'b00;
    tick(); expf("sp_regrant", 2'b01, 4'd1, 1'b0);
    tick(); expf("sp_m0", 2'b01, 4'd0, 1'b0);
`endif

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    #3;
    if (n_chk < 12) $display("FAIL count: only %0d checks executed", n_chk);
    if (n_pass != n_chk) $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
